// File: rtl/adder_pkg.sv
// Shared definitions for multi-cycle arithmetic blocks: FSM state encoding
// and the segment-count derivation / width legality helpers.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of S-bit segments needed to cover a W-bit operand.
  function automatic int segs_of(input int w, input int s);
    return (s >= 1) ? (w / s) : 0;
  endfunction

  // A width pair is legal when the segment is at least one bit wide and
  // tiles the full operand exactly.
  function automatic bit width_ok(input int w, input int s);
    return (s >= 1) && (w >= s) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/cla_segment.sv
// S-bit generate/propagate adder slice with carry in and carry out.
module cla_segment #(
  parameter int S = 16
) (
  input  logic [S-1:0] a_i,
  input  logic [S-1:0] b_i,
  input  logic         cin_i,
  output logic [S-1:0] sum_o,
  output logic         cout_o
);

  logic [S-1:0] g;
  logic [S-1:0] p;
  logic [S:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Carry chain built from per-bit generate/propagate terms.
  always_comb begin
    logic carry;
    carry = cin_i;
    c     = '0;
    c[0]  = cin_i;
    for (int i = 0; i < S; i++) begin
      carry    = g[i] | (p[i] & carry);
      c[i + 1] = carry;
    end
  end

  assign sum_o  = p ^ c[S-1:0];
  assign cout_o = c[S];

endmodule

// File: rtl/segmented_wide_adder.sv
// W-bit adder that streams S-bit segments, LSB first, through one narrow
// slice. Carry is held in a register between segments; valid/ready on both
// the operand and result sides.
module segmented_wide_adder
  import adder_pkg::*;
#(
  parameter int W = 64,
  parameter int S = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int SEGS  = segs_of(W, S);
  localparam int CNT_W = $clog2(SEGS) + 1;
  localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(SEGS - 1);

  if (!width_ok(W, S)) begin : g_width_check
    $error("segmented_wide_adder: W=%0d must be a positive multiple of S=%0d", W, S);
  end

  state_e           state_q, state_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;

  logic [S-1:0]     seg_sum;
  logic             seg_cout;
  logic [W-1:0]     a_shift, b_shift, sum_shift;
  logic             accept;
  logic             last_seg;

  cla_segment #(.S(S)) u_slice (
    .a_i    (a_sh_q[S-1:0]),
    .b_i    (b_sh_q[S-1:0]),
    .cin_i  (carry_q),
    .sum_o  (seg_sum),
    .cout_o (seg_cout)
  );

  // A single segment fills the whole word, so there is nothing to shift in
  // from above; otherwise new bits enter at the top as the word drains.
  if (SEGS == 1) begin : g_one_seg
    assign a_shift   = '0;
    assign b_shift   = '0;
    assign sum_shift = seg_sum;
  end else begin : g_multi_seg
    assign a_shift   = {{S{1'b0}}, a_sh_q[W-1:S]};
    assign b_shift   = {{S{1'b0}}, b_sh_q[W-1:S]};
    assign sum_shift = {seg_sum, sum_q[W-1:S]};
  end

  assign accept   = in_valid && (state_q == IDLE);
  assign last_seg = (state_q == RUN) && (seg_cnt_q == LAST_SEG);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept, run SEGS segments, hold result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_seg)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; never both high.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next state: load on accept, shift one segment per RUN cycle.
  always_comb begin
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    carry_d   = carry_q;
    seg_cnt_d = seg_cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    if (accept) begin
      a_sh_d    = a;
      b_sh_d    = b;
      carry_d   = cin;
      seg_cnt_d = '0;
    end else if (state_q == RUN) begin
      a_sh_d    = a_shift;
      b_sh_d    = b_shift;
      carry_d   = seg_cout;
      seg_cnt_d = seg_cnt_q + CNT_W'(1);
      sum_d     = sum_shift;
      if (last_seg) cout_d = seg_cout;
    end
  end

  // Datapath registers; reset clears everything so no stale result leaks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      carry_q   <= 1'b0;
      seg_cnt_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      carry_q   <= carry_d;
      seg_cnt_q <= seg_cnt_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_segmented_wide_adder.sv
// Bench for segmented_wide_adder: directed cases on a W=64/S=16 instance,
// then random traffic with random out_ready stalls on that instance and on
// a W=32/S=32 (single segment) instance, both checked against a + b + cin.
module tb_segmented_wide_adder;

  localparam int SEGS0 = 4;
  localparam int SEGS1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv0, ir0, ov0, or0, ci0, co0;
  logic [63:0] a0, b0, s0;
  logic        iv1, ir1, ov1, or1, ci1, co1;
  logic [31:0] a1, b1, s1;

  logic or0_force, or1_force, or0_rnd, or1_rnd, rnd_or;
  assign or0 = rnd_or ? or0_rnd : or0_force;
  assign or1 = rnd_or ? or1_rnd : or1_force;

  int total = 0;
  int bad   = 0;

  segmented_wide_adder #(.W(64), .S(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .a(a0), .b(b0), .cin(ci0), .out_valid(ov0), .out_ready(or0),
    .sum(s0), .cout(co0)
  );

  segmented_wide_adder #(.W(32), .S(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .cin(ci1), .out_valid(ov1), .out_ready(or1),
    .sum(s1), .cout(co1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted operand set queues a + b + cin.
  logic [64:0] q0[$];
  logic [32:0] q1[$];
  int          acc0[$];
  int          last_acc0 = 0, last_acc1 = 0;
  logic        ov0_prev = 1'b0, ov1_prev = 1'b0;

  // Compare process for dut0.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      ov0_prev = 1'b0;
    end else begin
      chk("excl0", {127'd0, ir0 & ov0}, 128'd0);
      if (ov0) begin
        if (!ov0_prev) chk("lat0", cyc - last_acc0, SEGS0);
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL spur0: out_valid with no pending operation, sum=%0h", s0);
        end else begin
          chk("res0", {co0, s0}, q0[0]);
          if (or0) void'(q0.pop_front());
        end
      end
      if (iv0 && ir0) begin
        q0.push_back({1'b0, a0} + {1'b0, b0} + 65'(ci0));
        last_acc0 = cyc + 1;
        acc0.push_back(cyc + 1);
      end
      ov0_prev = ov0;
    end
  end

  // Compare process for dut1.
  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
      ov1_prev = 1'b0;
    end else begin
      chk("excl1", {127'd0, ir1 & ov1}, 128'd0);
      if (ov1) begin
        if (!ov1_prev) chk("lat1", cyc - last_acc1, SEGS1);
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL spur1: out_valid with no pending operation, sum=%0h", s1);
        end else begin
          chk("res1", {co1, s1}, q1[0]);
          if (or1) void'(q1.pop_front());
        end
      end
      if (iv1 && ir1) begin
        q1.push_back({1'b0, a1} + {1'b0, b1} + 33'(ci1));
        last_acc1 = cyc + 1;
      end
      ov1_prev = ov1;
    end
  end

  // Random out_ready stalls.
  initial begin
    or0_rnd = 1'b0;
    or1_rnd = 1'b0;
    forever begin
      @(posedge clk); #1;
      or0_rnd = ($urandom_range(0, 2) != 0);
      or1_rnd = ($urandom_range(0, 2) != 0);
    end
  end

  // Present operands, wait (bounded) for acceptance, then drop in_valid.
  task automatic send0(input logic [63:0] a, input logic [63:0] b, input logic c);
    int n = 0;
    a0 = a; b0 = b; ci0 = c; iv0 = 1'b1;
    @(negedge clk);
    while (!ir0 && n < 200) begin @(negedge clk); n++; end
    if (!ir0) begin
      total++; bad++;
      $display("FAIL send0: in_ready stuck at %0b, required 1", ir0);
    end
    @(posedge clk); #1;
    iv0 = 1'b0; a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom}; ci0 = 1'($urandom);
  endtask

  task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic c);
    int n = 0;
    a1 = a; b1 = b; ci1 = c; iv1 = 1'b1;
    @(negedge clk);
    while (!ir1 && n < 200) begin @(negedge clk); n++; end
    if (!ir1) begin
      total++; bad++;
      $display("FAIL send1: in_ready stuck at %0b, required 1", ir1);
    end
    @(posedge clk); #1;
    iv1 = 1'b0; a1 = $urandom; b1 = $urandom; ci1 = 1'($urandom);
  endtask

  task automatic wait_ov0();
    int n = 0;
    @(negedge clk);
    while (!ov0 && n < 100) begin @(negedge clk); n++; end
    if (!ov0) begin
      total++; bad++;
      $display("FAIL wait_ov0: out_valid=%0b after timeout, required 1", ov0);
    end
  endtask

  // Wait for a result, check it against a literal, then take it.
  task automatic recv0(input string name, input logic [64:0] exp);
    wait_ov0();
    chk(name, {co0, s0}, exp);
    @(posedge clk); #1; or0_force = 1'b1;
    @(posedge clk); #1; or0_force = 1'b0;
  endtask

  task automatic rand0(input int n);
    logic [63:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? ~a : {$urandom, $urandom};
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send0(a, b, 1'($urandom));
    end
  endtask

  task automatic rand1(input int n);
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? ~a : 32'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send1(a, b, 1'($urandom));
    end
  endtask

  initial begin
    int idx;
    int n;
    rst_n = 1'b0; rnd_or = 1'b0; or0_force = 1'b0; or1_force = 1'b0;
    iv0 = 1'b0; a0 = '0; b0 = '0; ci0 = 1'b0;
    iv1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {127'd0, ir0}, 128'd1);
    chk("rst_valid", {127'd0, ov0}, 128'd0);
    chk("rst_sum",   {63'd0, co0, s0}, 128'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // All-ones plus one ripples the carry through every segment.
    send0(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    recv0("ones_plus_one", {1'b1, 64'h0});

    send0(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    recv0("comp_cin1", {1'b1, 64'h0});
    send0(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
    recv0("comp_cin0", {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});

    // Backpressure with new operands waiting.
    send0(64'h10, 64'h20, 1'b0);
    wait_ov0();
    @(posedge clk); #1;
    iv0 = 1'b1; a0 = 64'd100; b0 = 64'd200; ci0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", {127'd0, ov0}, 128'd1);
      chk("bp_ready", {127'd0, ir0}, 128'd0);
      chk("bp_hold",  {co0, s0}, {1'b0, 64'h30});
    end
    @(posedge clk); #1; or0_force = 1'b1;
    @(posedge clk); #1; or0_force = 1'b0;
    @(negedge clk);
    chk("bp_idle", {127'd0, ir0}, 128'd1);
    @(posedge clk); #1; iv0 = 1'b0;
    recv0("bp_next", {1'b0, 64'd301});

    // Reset two RUN cycles into an operation.
    send0(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {127'd0, ov0}, 128'd0);
    chk("mid_rst_ready", {127'd0, ir0}, 128'd1);
    chk("mid_rst_sum",   {63'd0, co0, s0}, 128'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    send0(64'd5, 64'd7, 1'b0);
    recv0("after_rst", {1'b0, 64'd12});

    // Back-to-back with out_ready held high.
    or0_force = 1'b1;
    idx = acc0.size();
    send0(64'd1, 64'd1, 1'b0);
    wait_ov0();
    chk("b2b_0", {co0, s0}, {1'b0, 64'd2});
    send0(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    wait_ov0();
    chk("b2b_1", {co0, s0}, {1'b1, 64'd0});
    send0(64'd0, 64'd0, 1'b1);
    wait_ov0();
    chk("b2b_2", {co0, s0}, {1'b0, 64'd1});
    chk("b2b_gap1", acc0[idx + 1] - acc0[idx], 6);
    chk("b2b_gap2", acc0[idx + 2] - acc0[idx + 1], 6);
    @(posedge clk); #1; or0_force = 1'b0;

    // Random regression on both instances concurrently.
    rnd_or = 1'b1;
    fork
      rand0(500);
      rand1(500);
    join
    rnd_or = 1'b0; or0_force = 1'b1; or1_force = 1'b1;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin @(posedge clk); n++; end
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/segmented_wide_adder.md
# segmented_wide_adder

Sequential wide adder that computes a W-bit sum by streaming S-bit segments, least significant first, through a single S-bit carry-lookahead slice. The carry is held in a register between segments. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency (W/S cycles) for the area of one narrow adder, and is used where full-width single-cycle adders do not meet timing.

## Interface
- W, 64: total operand and result width. Must be an integer multiple of S.
- S, 16: segment width, i.e. the width of the internal carry-lookahead slice, S ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand set a/b/cin is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  W  addend.
- b  input  W  addend.
- cin  input  1  carry into segment 0.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  registered result a+b+cin, modulo 2^W.
- cout  output  1  registered carry out of bit W-1.

## Operation
- SEGS = W/S. An elaboration-time check fails if W % S != 0 or S < 1.
- State machine has three states: IDLE, RUN, DONE.
- **IDLE:** in_ready=1 and out_valid=0.
  - On in_valid && in_ready: load a_sh←a, b_sh←b, carry←cin, seg_cnt←0; go to RUN.
- **RUN:** in_ready=0 and out_valid=0. Each cycle:
  - Add a_sh[S-1:0] + b_sh[S-1:0] + carry in the slice.
  - sum_r←{seg_sum, sum_r[W-1:S]}, carry←seg_cout.
  - a_sh and b_sh shift right by S; seg_cnt++.
  - On the cycle with seg_cnt==SEGS-1: cout_r←seg_cout; go to DONE.
- **DONE:** out_valid=1 and in_ready=0; sum and cout are stable.
  - On out_ready: go to IDLE.
  - sum and cout keep their value until the next operation starts shifting.
- in_valid is ignored outside IDLE. The upstream stage must hold a/b/cin only until the handshake cycle.
- Arithmetic is unsigned modulo 2^W; cout is the true carry out. Signed overflow detection is the consumer's job.
- sum is meaningful only while out_valid=1; it contains partial data during RUN.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, sum=0, cout=0.
  - Also reset: carry=0, seg_cnt=0, a_sh=0, b_sh=0.
- Handshakes are sampled only while rst_n=1.
- Latency: out_valid rises SEGS cycles after the accepting edge. With SEGS=1 this is 1 cycle.
- Throughput: at most one operation per SEGS+2 cycles (accept edge, SEGS RUN edges, output handshake edge) with out_ready tied high.
- Backpressure: DONE is held indefinitely while out_ready=0, with no change to sum or cout.
- in_ready and out_valid are never high together.
- Reset mid-operation (any state): the operation is abandoned, all registers return to reset values, and no partial result is presented. The next accepted operation is computed correctly.
- seg_cnt is $clog2(SEGS)+1 bits wide. It does not wrap within an operation; it is cleared on accept.

## Structure
- Shared package adder_pkg holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the SEGS derivation and width-check helper, reused by other multi-cycle arithmetic blocks.
- One combinational sub-module, cla_segment (parameter S): S-bit generate/propagate adder with cin, sum, cout.
- The top level holds the FSM, shift registers, carry register and handshake logic.

## Test plan
- W=64, S=16: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0, cout=1, out_valid exactly 4 cycles after accept.
- a=0x0123_4567_89AB_CDEF, b=0xFEDC_BA98_7654_3210, cin=1 → sum=0x0000_0000_0000_0000, cout=1. Same operands with cin=0 → sum=0xFFFF_FFFF_FFFF_FFFF, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - Required: out_valid=1, sum/cout unchanged, in_ready=0, no new operation accepted.
  - Required: after out_ready=1, the pending operands are accepted on the next IDLE cycle.
- Reset mid-operation: assert rst_n=0 after 2 RUN cycles → out_valid=0, sum=0, cout=0, in_ready=1. The following operation 5+7+0 yields sum=12, cout=0.
- Back-to-back streaming with out_ready=1: three ops (1+1, 0x8000_0000_0000_0000+0x8000_0000_0000_0000, 0+0 with cin=1) → results 2/0, 0/1, 1/0 in order, with accepts spaced 6 cycles apart.
- Random regression: 1000 random operand sets, W=64/S=16 and W=32/S=32 (SEGS=1), with random out_ready stalls → every result matches the reference {cout,sum} = a+b+cin.
